// File: rtl/bit_serial_adder.sv
// Bit-serial adder that adds two WIDTH-bit operands LSB first.
// One full-adder cell is reused every cycle, and the carry is held in a flop between cycles.
// Control uses a start/busy/done handshake driven by a three-state FSM.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CNT_W-1:0] bit_cnt;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;
  logic [WIDTH-1:0] sum_shifted;

  // Shared full-adder cell working on the current LSBs and the stored carry
  always_comb begin
    fa_s        = a_sr[0] ^ b_sr[0] ^ carry;
    fa_co       = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    last_bit    = (bit_cnt == LAST_BIT);
    sum_shifted = {fa_s, sum_sr[WIDTH-1:1]};
  end

  // State register; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start only matters in IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ADD;
      ADD:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, serial shifting, and the registered result on the final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      sum_sr   <= '0;
      carry    <= 1'b0;
      bit_cnt  <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            carry   <= c_in;
            bit_cnt <= '0;
          end
        end
        ADD: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          sum_sr  <= sum_shifted;
          carry   <= fa_co;
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (last_bit) begin
            sum      <= sum_shifted;
            c_out    <= fa_co;
            overflow <= carry ^ fa_co;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake outputs decoded straight from the state register
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

endmodule
